// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
//   Shares one single-cycle ALU between NUM_REQ issue ports. Each port owns a
//   one-entry holding slot that is scrubbed every cycle by branch kill/resolve
//   and flush. A round-robin scheduler picks one live slot per cycle and drives
//   the ALU request combinationally from the slot registers. Issue is held off
//   while writeback is stalled.
//
// Ports:
//   clock, reset                 clock, synchronous active-low reset
//   req_valid/req_ready          per-port handshake into the holding slots
//   req_br_mask, req_payload     per-port branch mask / opaque payload (flattened)
//   brupdate_resolve_mask        branches resolved this cycle (cleared from masks)
//   brupdate_mispredict_mask     branches mispredicted this cycle (kill matching)
//   flush                        kills every slot and every incoming request
//   wb_stall                     no issue this cycle
//   alu_req_*                    request to the ALU unit, zero when not granted
//   stall_cycles                 saturating count of cycles with live work, no grant
module alu_issue_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int BR_MASK_W = 16,
  parameter int PAYLOAD_W = 64,
  parameter int CNT_W     = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*BR_MASK_W-1:0]   req_br_mask,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload,
  input  logic [BR_MASK_W-1:0]           brupdate_resolve_mask,
  input  logic [BR_MASK_W-1:0]           brupdate_mispredict_mask,
  input  logic                           flush,
  input  logic                           wb_stall,
  output logic                           alu_req_valid,
  output logic [BR_MASK_W-1:0]           alu_req_br_mask,
  output logic [PAYLOAD_W-1:0]           alu_req_payload,
  output logic [1:0]                     alu_req_grant_id,
  output logic [CNT_W-1:0]               stall_cycles
);

  logic [NUM_REQ-1:0]   slot_valid;
  logic [BR_MASK_W-1:0] slot_br_mask [NUM_REQ];
  logic [PAYLOAD_W-1:0] slot_payload [NUM_REQ];
  logic [1:0]           rr_ptr;

  logic [NUM_REQ-1:0]   kill;
  logic [NUM_REQ-1:0]   live;
  logic [NUM_REQ-1:0]   in_kill;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   accept;
  logic                 any_grant;
  logic                 issue_block;
  logic [1:0]           rr_ptr_next;
  int                   idx;

  // Everything combinational lives in one block so the kill -> grant -> ready
  // chain is evaluated in order without cross-block vector dependencies.
  always_comb begin
    kill             = '0;
    live             = '0;
    in_kill          = '0;
    grant            = '0;
    accept           = '0;
    req_ready        = '0;
    any_grant        = 1'b0;
    idx              = 0;
    alu_req_br_mask  = '0;
    alu_req_payload  = '0;
    alu_req_grant_id = '0;
    rr_ptr_next      = rr_ptr;
    // A reset cycle discards the slots, so nothing may be issued from them.
    issue_block      = wb_stall | ~reset;

    for (int i = 0; i < NUM_REQ; i++) begin
      kill[i]    = flush | (|(brupdate_mispredict_mask & slot_br_mask[i]));
      live[i]    = slot_valid[i] & ~kill[i];
      in_kill[i] = flush |
                   (|(brupdate_mispredict_mask & req_br_mask[i*BR_MASK_W +: BR_MASK_W]));
    end

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_grant && !issue_block && (i == idx) && live[i]) begin
          any_grant = 1'b1;
          grant[i]  = 1'b1;
        end
      end
    end

    alu_req_valid = any_grant;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        alu_req_br_mask  = slot_br_mask[i] & ~brupdate_resolve_mask;
        alu_req_payload  = slot_payload[i];
        alu_req_grant_id = 2'(i);
        rr_ptr_next      = (i == NUM_REQ - 1) ? 2'd0 : 2'(i + 1);
      end
      // A slot frees up when empty, issuing, or being killed this cycle.
      req_ready[i] = ~slot_valid[i] | grant[i] | kill[i];
      accept[i]    = req_valid[i] & req_ready[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      slot_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_br_mask[i] <= '0;
        slot_payload[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          // A request already killed on arrival is consumed but not held.
          slot_valid[i]   <= ~in_kill[i];
          slot_br_mask[i] <= req_br_mask[i*BR_MASK_W +: BR_MASK_W] & ~brupdate_resolve_mask;
          slot_payload[i] <= req_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end else if (grant[i] | kill[i]) begin
          slot_valid[i] <= 1'b0;
        end else begin
          slot_br_mask[i] <= slot_br_mask[i] & ~brupdate_resolve_mask;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr <= 2'd0;
    end else begin
      rr_ptr <= rr_ptr_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if ((|live) && !any_grant && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: expected ALU requests are queued when
// stimulus is driven and popped when the DUT raises alu_req_valid.
module tb_alu_issue_arbiter;
  localparam int N  = 2;
  localparam int BW = 16;
  localparam int PW = 64;
  localparam int CW = 3;

  logic              clock;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*BW-1:0]   req_br_mask;
  logic [N*PW-1:0]   req_payload;
  logic [BW-1:0]     brupdate_resolve_mask;
  logic [BW-1:0]     brupdate_mispredict_mask;
  logic              flush;
  logic              wb_stall;
  logic              alu_req_valid;
  logic [BW-1:0]     alu_req_br_mask;
  logic [PW-1:0]     alu_req_payload;
  logic [1:0]        alu_req_grant_id;
  logic [CW-1:0]     stall_cycles;

  typedef struct packed {
    logic [1:0]    gid;
    logic [BW-1:0] mask;
    logic [PW-1:0] pay;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  alu_issue_arbiter #(.NUM_REQ(N), .BR_MASK_W(BW), .PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .req_valid                (req_valid),
    .req_ready                (req_ready),
    .req_br_mask              (req_br_mask),
    .req_payload              (req_payload),
    .brupdate_resolve_mask    (brupdate_resolve_mask),
    .brupdate_mispredict_mask (brupdate_mispredict_mask),
    .flush                    (flush),
    .wb_stall                 (wb_stall),
    .alu_req_valid            (alu_req_valid),
    .alu_req_br_mask          (alu_req_br_mask),
    .alu_req_payload          (alu_req_payload),
    .alu_req_grant_id         (alu_req_grant_id),
    .stall_cycles             (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout reached before end of test sequence");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] gid, input logic [BW-1:0] mask, input logic [PW-1:0] pay);
    exp_t e;
    e.gid  = gid;
    e.mask = mask;
    e.pay  = pay;
    sb.push_back(e);
  endtask

  task automatic set_req(input int p, input logic v, input logic [BW-1:0] m, input logic [PW-1:0] pl);
    req_valid[p]             = v;
    req_br_mask[p*BW +: BW]  = m;
    req_payload[p*PW +: PW]  = pl;
  endtask

  // Checks the ALU request at the falling edge; a valid request is matched
  // against the head of the scoreboard.
  task automatic sample(input logic expv);
    exp_t e;
    @(negedge clock);
    chk("alu_req_valid", alu_req_valid, expv);
    if (alu_req_valid === 1'b1) begin
      chk("issue_with_empty_scoreboard", 64'(sb.size() == 0), 64'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("alu_req_grant_id", alu_req_grant_id, e.gid);
        chk("alu_req_br_mask", alu_req_br_mask, e.mask);
        chk("alu_req_payload", alu_req_payload, e.pay);
      end
    end else begin
      chk("idle_grant_id", alu_req_grant_id, 64'd0);
      chk("idle_br_mask", alu_req_br_mask, 64'd0);
      chk("idle_payload", alu_req_payload, 64'd0);
    end
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    sample(1'b0);
    adv();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = '0;
    req_br_mask = '0;
    req_payload = '0;
    brupdate_resolve_mask = '0;
    brupdate_mispredict_mask = '0;
    flush = 1'b0;
    wb_stall = 1'b0;
    adv();

    // reset held two cycles
    sample(1'b0);
    chk("reset_ready", req_ready, 64'h3);
    chk("reset_stall_cycles", stall_cycles, 64'd0);
    adv();
    sample(1'b0);
    adv();
    reset = 1'b1;

    // single request, one-cycle accept-to-issue
    set_req(0, 1'b1, 16'h0001, 64'hA5);
    push(2'd0, 16'h0001, 64'hA5);
    sample(1'b0);
    chk("single_ready0", req_ready[0], 64'd1);
    adv();
    set_req(0, 1'b0, '0, '0);
    sample(1'b1);
    adv();
    sample(1'b0);
    adv();

    // round robin with both ports continuously valid
    pulse_reset();
    set_req(0, 1'b1, '0, 64'h10);
    set_req(1, 1'b1, '0, 64'h20);
    push(2'd0, '0, 64'h10); push(2'd1, '0, 64'h20);
    push(2'd0, '0, 64'h10); push(2'd1, '0, 64'h20);
    push(2'd0, '0, 64'h10); push(2'd1, '0, 64'h20);
    sample(1'b0);
    adv();
    sample(1'b1);
    chk("rr_ready_t1", req_ready, 64'h1);
    adv();
    sample(1'b1);
    chk("rr_ready_t2", req_ready, 64'h2);
    adv();
    sample(1'b1);
    adv();
    sample(1'b1);
    adv();
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    sample(1'b1);
    adv();
    sample(1'b1);
    adv();
    sample(1'b0);
    adv();

    // mispredict kills slot0 and an incoming port0 request; port1 issues
    set_req(0, 1'b1, 16'h0004, 64'h30);
    set_req(1, 1'b1, 16'h0008, 64'h40);
    sample(1'b0);
    adv();
    set_req(0, 1'b1, 16'h0004, 64'h99);
    set_req(1, 1'b0, '0, '0);
    brupdate_mispredict_mask = 16'h0004;
    push(2'd1, 16'h0008, 64'h40);
    sample(1'b1);
    chk("kill_ready0", req_ready[0], 64'd1);
    adv();
    set_req(0, 1'b0, '0, '0);
    brupdate_mispredict_mask = '0;
    sample(1'b0);
    adv();
    sample(1'b0);
    adv();

    // resolve clears bits while held and in the issue cycle
    set_req(0, 1'b1, 16'h0006, 64'h50);
    sample(1'b0);
    adv();
    set_req(0, 1'b0, '0, '0);
    wb_stall = 1'b1;
    brupdate_resolve_mask = 16'h0002;
    sample(1'b0);
    adv();
    wb_stall = 1'b0;
    brupdate_resolve_mask = '0;
    push(2'd0, 16'h0004, 64'h50);
    sample(1'b1);
    adv();
    set_req(0, 1'b1, 16'h0006, 64'h51);
    sample(1'b0);
    adv();
    set_req(0, 1'b0, '0, '0);
    wb_stall = 1'b1;
    brupdate_resolve_mask = 16'h0002;
    sample(1'b0);
    adv();
    wb_stall = 1'b0;
    brupdate_resolve_mask = 16'h0004;
    push(2'd0, 16'h0000, 64'h51);
    sample(1'b1);
    adv();
    brupdate_resolve_mask = '0;
    sample(1'b0);
    adv();
    chk("resolve_stall_cycles", stall_cycles, 64'd2);

    // writeback stall for five cycles with both slots live
    pulse_reset();
    set_req(0, 1'b1, '0, 64'h60);
    set_req(1, 1'b1, '0, 64'h70);
    sample(1'b0);
    adv();
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    wb_stall = 1'b1;
    repeat (5) begin
      sample(1'b0);
      chk("wbstall_ready", req_ready, 64'h0);
      adv();
    end
    wb_stall = 1'b0;
    push(2'd0, '0, 64'h60);
    push(2'd1, '0, 64'h70);
    sample(1'b1);
    chk("wbstall_count5", stall_cycles, 64'd5);
    adv();
    sample(1'b1);
    adv();
    sample(1'b0);
    adv();

    // flush kills both slots and an incoming request
    set_req(0, 1'b1, '0, 64'h80);
    set_req(1, 1'b1, '0, 64'h90);
    sample(1'b0);
    adv();
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b1, '0, 64'h91);
    flush = 1'b1;
    sample(1'b0);
    chk("flush_ready_same", req_ready, 64'h3);
    adv();
    set_req(1, 1'b0, '0, '0);
    flush = 1'b0;
    sample(1'b0);
    chk("flush_ready_after", req_ready, 64'h3);
    adv();
    sample(1'b0);
    chk("flush_no_stall_count", stall_cycles, 64'd5);
    adv();

    // reset mid-operation with rr_ptr pointing at port1
    set_req(0, 1'b1, '0, 64'hA0);
    sample(1'b0);
    adv();
    set_req(0, 1'b1, '0, 64'hA1);
    set_req(1, 1'b1, '0, 64'hB1);
    push(2'd0, '0, 64'hA0);
    sample(1'b1);
    adv();
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    reset = 1'b0;
    sample(1'b0);
    adv();
    reset = 1'b1;
    set_req(0, 1'b1, '0, 64'hC0);
    set_req(1, 1'b1, '0, 64'hD0);
    sample(1'b0);
    chk("rst_mid_ready", req_ready, 64'h3);
    chk("rst_mid_stall_cycles", stall_cycles, 64'd0);
    adv();
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    push(2'd0, '0, 64'hC0);
    push(2'd1, '0, 64'hD0);
    sample(1'b1);
    adv();
    sample(1'b1);
    adv();
    sample(1'b0);
    adv();

    // stall counter saturates at 2^CW-1
    set_req(0, 1'b1, '0, 64'hE0);
    sample(1'b0);
    adv();
    set_req(0, 1'b0, '0, '0);
    wb_stall = 1'b1;
    repeat (10) begin
      sample(1'b0);
      adv();
    end
    chk("stall_saturate", stall_cycles, 64'd7);
    wb_stall = 1'b0;
    push(2'd0, '0, 64'hE0);
    sample(1'b1);
    adv();
    chk("stall_hold_saturated", stall_cycles, 64'd7);
    sample(1'b0);
    adv();

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
